// File: rtl/dram_pkg.sv
// Shared types and helpers for the data-memory controller.
// Sizes, FSM states and byte-enable generation.
package dram_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  // Clear the low offset bits so the access sits on its natural boundary.
  function automatic logic [2:0] align_off(size_e sz, logic [2:0] off);
    unique case (sz)
      SZ_B:    return off;
      SZ_H:    return {off[2:1], 1'b0};
      SZ_W:    return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] byte_en(size_e sz, logic [2:0] off);
    logic [7:0] m;
    unique case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// Request/response handshake bundle between the CPU
// load/store path (master) and dram_ctrl (slave).
interface dram_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size,
        output req_signed, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size,
        input  req_signed, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dram_bank.sv
// Single-port synchronous-read RAM with per-lane write enables.
// Read-during-write returns the old word.
module dram_bank #(
    parameter int AW     = 16,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** AW;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we[l]) mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
        end
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dram_ctrl.sv
// Data-memory controller: sized loads/stores over a sync-read RAM.
// DRAM_CTRL_MISALIGN_TRAP_EN: misaligned or illegal sizes return rsp_err.
import dram_pkg::*;

module dram_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    dram_ctrl_if.slave  bus
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int WA_W  = ADDR_W - OFF_W;

    state_e            state;
    size_e             sz_q;
    logic [2:0]        off_q;
    logic              sgn_q;
    logic              hs;
    logic              bad;
    size_e             sz_in;
    logic [2:0]        off_raw;
    logic [2:0]        off_in;
    logic [7:0]        be8;
    logic [LANES-1:0]  we;
    logic              re;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ext;
    logic              sb;
    int                nbits;

    assign bus.req_ready = ~rst & ((state == IDLE) |
                                   ((state == RESP) & bus.rsp_ready));
    assign hs = bus.req_valid & bus.req_ready;

    always_comb begin
        sz_in = size_e'(bus.req_size);
        if (DATA_W == 32 && sz_in == SZ_D) sz_in = SZ_W;
        off_raw = '0;
        off_raw[OFF_W-1:0] = bus.req_addr[OFF_W-1:0];
        off_in = align_off(sz_in, off_raw);
        be8 = byte_en(sz_in, off_in);
`ifdef DRAM_CTRL_MISALIGN_TRAP_EN
        unique case (size_e'(bus.req_size))
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = bus.req_addr[0];
            SZ_W:    bad = |bus.req_addr[1:0];
            default: bad = (DATA_W == 32) | (|bus.req_addr[2:0]);
        endcase
`else
        bad = 1'b0;
`endif
    end

    // Sub-word stores replicate the low bytes; byte enables pick the lanes.
    always_comb begin
        unique case (sz_in)
            SZ_B:    wr_data = {LANES{bus.req_wdata[7:0]}};
            SZ_H:    wr_data = {(LANES/2){bus.req_wdata[15:0]}};
            SZ_W:    wr_data = {(LANES/4){bus.req_wdata[31:0]}};
            default: wr_data = bus.req_wdata;
        endcase
    end

    assign we = be8[LANES-1:0] & {LANES{hs & bus.req_we & ~bad}};
    assign re = hs & ~bus.req_we & ~bad;

    dram_bank #(.AW(WA_W), .DATA_W(DATA_W)) u_bank (
        .clk   (clk),
        .re    (re),
        .we    (we),
        .addr  (bus.req_addr[ADDR_W-1:OFF_W]),
        .wdata (wr_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        sh = ram_rdata >> {off_q, 3'b000};
        unique case (sz_q)
            SZ_B:    begin sb = sh[7];  nbits = 8;  end
            SZ_H:    begin sb = sh[15]; nbits = 16; end
            SZ_W:    begin sb = sh[31]; nbits = 32; end
            default: begin sb = 1'b0;   nbits = DATA_W; end
        endcase
        ext = sh;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits) ext[i] = sgn_q & sb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            sz_q          <= SZ_B;
            off_q         <= '0;
            sgn_q         <= 1'b0;
        end else begin
            unique case (state)
                READ: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= ext;
                end
                default: begin
                    if (hs) begin
                        sz_q          <= sz_in;
                        off_q         <= off_in;
                        sgn_q         <= bus.req_signed;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= bad;
                        if (bad | bus.req_we) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                        end else begin
                            state         <= READ;
                            bus.rsp_valid <= 1'b0;
                        end
                    end else if (state == IDLE || bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: vector table, corner sequences,
// random traffic against a byte-array memory model.
module tb_dram_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dram_ctrl_if #(.ADDR_W(18), .DATA_W(32)) bif ();
    dram_ctrl_if #(.ADDR_W(12), .DATA_W(64)) bif64 ();

    dram_ctrl #(.ADDR_W(18), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    dram_ctrl #(.ADDR_W(12), .DATA_W(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bif64)
    );

    typedef struct {
        bit          we;
        int          addr;
        int          sz;
        bit          sg;
        logic [31:0] wd;
        logic [31:0] ed;
        bit          ee;
    } vec_t;

    vec_t       tv [18];
    logic [7:0] mdl [256];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Byte-level model: natural alignment, little-endian, optional trap.
    function automatic void model(input bit we, input int a, input int sz,
                                  input bit sg, input logic [31:0] wd,
                                  output logic [31:0] d, output bit e);
        int n;
        int base;
        e = 1'b0;
        d = '0;
        if (sz == 3) begin
`ifdef DRAM_CTRL_MISALIGN_TRAP_EN
            e = 1'b1;
            return;
`else
            sz = 2;
`endif
        end
        n = 1 << sz;
`ifdef DRAM_CTRL_MISALIGN_TRAP_EN
        if (a % n != 0) begin
            e = 1'b1;
            return;
        end
`endif
        base = a - (a % n);
        if (we) begin
            for (int i = 0; i < n; i++) mdl[base+i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) d[8*i +: 8] = mdl[base+i];
            if (sg && n < 4 && d[8*n-1]) d = d | ~((32'h1 << (8*n)) - 1);
        end
    endfunction

    task automatic acc(input bit we, input int a, input int sz, input bit sg,
                       input logic [31:0] wd, input int stall,
                       input logic [31:0] ed, input bit ee, input string nm);
        int lat;
        @(negedge clk);
        bif.req_valid  = 1'b1;
        bif.req_we     = we;
        bif.req_addr   = 18'(a);
        bif.req_size   = 2'(sz);
        bif.req_signed = sg;
        bif.req_wdata  = wd;
        bif.rsp_ready  = 1'b0;
        chk({nm, " rdy"}, 64'(bif.req_ready), 64'd1);
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bif.rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " lat"}, 64'(lat), (ee || we) ? 64'd1 : 64'd2);
        chk({nm, " data"}, 64'(bif.rsp_rdata), 64'(ed));
        chk({nm, " err"}, 64'(bif.rsp_err), 64'(ee));
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk({nm, " hold"}, {31'd0, bif.rsp_valid, bif.rsp_rdata},
                {31'd0, 1'b1, ed});
        end
        bif.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bif.rsp_ready = 1'b0;
    endtask

    task automatic acc64(input bit we, input int a, input int sz, input bit sg,
                         input logic [63:0] wd, input logic [63:0] ed,
                         input string nm);
        int lat;
        @(negedge clk);
        bif64.req_valid  = 1'b1;
        bif64.req_we     = we;
        bif64.req_addr   = 12'(a);
        bif64.req_size   = 2'(sz);
        bif64.req_signed = sg;
        bif64.req_wdata  = wd;
        @(posedge clk);
        #1 bif64.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bif64.rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " lat"}, 64'(lat), we ? 64'd1 : 64'd2);
        chk({nm, " data"}, bif64.rsp_rdata, ed);
        chk({nm, " err"}, 64'(bif64.rsp_err), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd;
        logic [31:0] ed;
        bit          ee;
        bit          we;
        bit          sg;
        int          a;
        int          sz;
        int          st;

        rst = 1'b1;
        bif.req_valid = 1'b0;  bif.req_we = 1'b0;  bif.req_addr = '0;
        bif.req_size = '0;     bif.req_signed = 1'b0;
        bif.req_wdata = '0;    bif.rsp_ready = 1'b0;
        bif64.req_valid = 1'b0; bif64.req_we = 1'b0; bif64.req_addr = '0;
        bif64.req_size = '0;    bif64.req_signed = 1'b0;
        bif64.req_wdata = '0;   bif64.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst valid", 64'(bif.rsp_valid), 64'd0);
        chk("rst rdata", 64'(bif.rsp_rdata), 64'd0);
        chk("rst err", 64'(bif.rsp_err), 64'd0);
        chk("rst ready", 64'(bif.req_ready), 64'd0);
        rst = 1'b0;
        #1 chk("ready after rst", 64'(bif.req_ready), 64'd1);

        tv[0]  = '{1, 'h100, 2, 0, 32'h8899AABB, 32'h0, 0};
        tv[1]  = '{0, 'h103, 0, 0, 32'h0, 32'h00000088, 0};
        tv[2]  = '{0, 'h103, 0, 1, 32'h0, 32'hFFFFFF88, 0};
        tv[3]  = '{0, 'h102, 1, 0, 32'h0, 32'h00008899, 0};
        tv[4]  = '{0, 'h102, 1, 1, 32'h0, 32'hFFFF8899, 0};
        tv[5]  = '{1, 'h100, 2, 0, 32'h11223344, 32'h0, 0};
        tv[6]  = '{1, 'h101, 0, 0, 32'hFFFFFF5A, 32'h0, 0};
        tv[7]  = '{0, 'h100, 2, 0, 32'h0, 32'h11225A44, 0};
        tv[8]  = '{0, 'h101, 0, 1, 32'h0, 32'h0000005A, 0};
        tv[10] = '{0, 'h100, 2, 0, 32'h0, 32'h11225A44, 0};
        tv[11] = '{1, 'h104, 2, 0, 32'h0, 32'h0, 0};
        tv[12] = '{1, 'h106, 1, 0, 32'h1234BEEF, 32'h0, 0};
        tv[13] = '{0, 'h104, 2, 0, 32'h0, 32'hBEEF0000, 0};
`ifdef DRAM_CTRL_MISALIGN_TRAP_EN
        tv[9]  = '{0, 'h102, 2, 0, 32'h0, 32'h0, 1};
        tv[14] = '{0, 'h107, 1, 0, 32'h0, 32'h0, 1};
        tv[15] = '{0, 'h104, 3, 1, 32'h0, 32'h0, 1};
        tv[16] = '{1, 'h105, 1, 0, 32'h0000CAFE, 32'h0, 1};
        tv[17] = '{0, 'h104, 2, 0, 32'h0, 32'hBEEF0000, 0};
`else
        tv[9]  = '{0, 'h102, 2, 0, 32'h0, 32'h11225A44, 0};
        tv[14] = '{0, 'h107, 1, 0, 32'h0, 32'h0000BEEF, 0};
        tv[15] = '{0, 'h104, 3, 1, 32'h0, 32'hBEEF0000, 0};
        tv[16] = '{1, 'h105, 1, 0, 32'h0000CAFE, 32'h0, 0};
        tv[17] = '{0, 'h104, 2, 0, 32'h0, 32'hBEEFCAFE, 0};
`endif
        for (int i = 0; i < 18; i++) begin
            acc(tv[i].we, tv[i].addr, tv[i].sz, tv[i].sg, tv[i].wd, i % 3,
                tv[i].ed, tv[i].ee, $sformatf("vec%0d", i));
        end

        // Back-to-back store then load with rsp_ready held high.
        @(negedge clk);
        bif.rsp_ready = 1'b1;
        bif.req_valid = 1'b1;  bif.req_we = 1'b1;  bif.req_addr = 18'h200;
        bif.req_size = 2'd2;   bif.req_signed = 1'b0;
        bif.req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 bif.req_we = 1'b0;
        bif.req_signed = 1'b1;
        @(negedge clk);
        chk("b2b st rsp", {bif.rsp_valid, bif.rsp_err, bif.rsp_rdata},
            {1'b1, 1'b0, 32'h0});
        chk("b2b rdy", 64'(bif.req_ready), 64'd1);
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b ld wait", 64'(bif.rsp_valid), 64'd0);
        @(negedge clk);
        chk("b2b ld rsp", {bif.rsp_valid, bif.rsp_rdata}, {1'b1, 32'hDEADBEEF});
        @(posedge clk);
        #1 bif.rsp_ready = 1'b0;

        // Stall a load response; a pending store must not be accepted.
        @(negedge clk);
        bif.req_valid = 1'b1;  bif.req_we = 1'b0;  bif.req_addr = 18'h200;
        bif.req_size = 2'd2;   bif.req_signed = 1'b0;
        @(posedge clk);
        #1 bif.req_we = 1'b1;
        bif.req_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d", i),
                {bif.rsp_valid, bif.req_ready, bif.rsp_rdata},
                {1'b1, 1'b0, 32'hDEADBEEF});
            @(negedge clk);
        end
        rst = 1'b1;
        #1 chk("rst drop", {bif.rsp_valid, bif.req_ready}, 64'd0);
        bif.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acc(0, 'h200, 2, 0, 32'h0, 0, 32'hDEADBEEF, 0, "persist");

        // Random traffic over a model-initialised region.
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            model(1, i*4, 2, 0, wd, ed, ee);
            acc(1, i*4, 2, 0, wd, 0, ed, ee, "init");
        end
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 255);
            sz = $urandom_range(0, 3);
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            st = $urandom_range(0, 2);
            model(we, a, sz, sg, wd, ed, ee);
            acc(we, a, sz, sg, wd, st, ed, ee, $sformatf("rnd%0d", i));
        end

        // 64-bit bank.
        acc64(1, 'h8, 3, 0, 64'h0123456789ABCDEF, 64'h0, "sd");
        acc64(0, 'hC, 2, 1, 64'h0, 64'h0000000001234567, "lw hi");
        acc64(0, 'h8, 3, 0, 64'h0, 64'h0123456789ABCDEF, "ld");
        acc64(0, 'h8, 2, 1, 64'h0, 64'hFFFFFFFF89ABCDEF, "lw lo");
        acc64(0, 'hA, 1, 1, 64'h0, 64'hFFFFFFFFFFFF89AB, "lh");
        acc64(0, 'hF, 0, 1, 64'h0, 64'h0000000000000001, "lb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
